// File: rtl/regfile_port_sequencer_if.sv
// rtl/regfile_port_sequencer_if.sv - core-side fetch/operand/writeback handshakes of the register file sequencer
interface regfile_port_sequencer_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   req_rs1;
    logic [AW-1:0]   req_rs2;
    logic            req_use_rs2;

    logic            op_valid;
    logic            op_ready;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;

    logic            wb_valid;
    logic            wb_ready;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;

    modport master (
        output req_valid, req_rs1, req_rs2, req_use_rs2, op_ready,
               wb_valid, wb_addr, wb_data,
        input  req_ready, op_valid, op_a, op_b, wb_ready
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_use_rs2, op_ready,
               wb_valid, wb_addr, wb_data,
        output req_ready, op_valid, op_a, op_b, wb_ready
    );
endinterface

// File: rtl/regfile_port_sequencer.sv
// rtl/regfile_port_sequencer.sv - serialises operand fetches and writebacks onto the single-port register file bus
module regfile_port_sequencer #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter bit WB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    regfile_port_sequencer_if.slave core,
    output logic                    rf_rd,
    output logic                    rf_wr,
    output logic [AW-1:0]           rf_addr,
    inout  wire  [XLEN-1:0]         rf_bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD1,
        S_RD2,
        S_OUT,
        S_WB
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   rs1_q, rs1_d;
    logic [AW-1:0]   rs2_q, rs2_d;
    logic            use_rs2_q, use_rs2_d;
    logic [AW-1:0]   wb_addr_q, wb_addr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic            op_valid_q, op_valid_d;
    logic            rf_rd_q, rf_rd_d;
    logic            rf_wr_q, rf_wr_d;
    logic [AW-1:0]   rf_addr_q, rf_addr_d;
    logic            req_ready_c;
    logic            wb_ready_c;

    always_comb begin
        state_d     = state_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        use_rs2_d   = use_rs2_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        req_ready_c = 1'b0;
        wb_ready_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Only the losing side sees its ready depend on the other valid,
                // so at most one handshake can complete per cycle.
                if (WB_FIRST) begin
                    wb_ready_c  = 1'b1;
                    req_ready_c = !core.wb_valid;
                end else begin
                    req_ready_c = 1'b1;
                    wb_ready_c  = !core.req_valid;
                end

                if (core.wb_valid && wb_ready_c) begin
                    if (core.wb_addr != '0) begin
                        wb_addr_d = core.wb_addr;
                        wb_data_d = core.wb_data;
                        state_d   = S_WB;
                    end
                end else if (core.req_valid && req_ready_c) begin
                    rs1_d     = core.req_rs1;
                    rs2_d     = core.req_rs2;
                    use_rs2_d = core.req_use_rs2;
                    op_a_d    = '0;
                    op_b_d    = '0;
                    if (core.req_rs1 != '0) begin
                        state_d = S_RD1;
                    end else if (core.req_use_rs2 && (core.req_rs2 != '0)) begin
                        state_d = S_RD2;
                    end else begin
                        state_d = S_OUT;
                    end
                end
            end
            S_RD1: begin
                op_a_d  = rf_bus;
                state_d = (use_rs2_q && (rs2_q != '0)) ? S_RD2 : S_OUT;
            end
            S_RD2: begin
                op_b_d  = rf_bus;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (core.op_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Bus controls are registered copies decoded from the state being entered.
        rf_rd_d    = (state_d == S_RD1) || (state_d == S_RD2);
        rf_wr_d    = (state_d == S_WB);
        op_valid_d = (state_d == S_OUT);
        case (state_d)
            S_RD1:   rf_addr_d = rs1_d;
            S_RD2:   rf_addr_d = rs2_d;
            S_WB:    rf_addr_d = wb_addr_d;
            default: rf_addr_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            use_rs2_q  <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            rf_rd_q    <= 1'b0;
            rf_wr_q    <= 1'b0;
            rf_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            use_rs2_q  <= use_rs2_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
            rf_rd_q    <= rf_rd_d;
            rf_wr_q    <= rf_wr_d;
            rf_addr_q  <= rf_addr_d;
        end
    end

    // Readies are gated by reset so they drop the moment rst_n falls.
    assign core.req_ready = req_ready_c && rst_n;
    assign core.wb_ready  = wb_ready_c && rst_n;
    assign core.op_valid  = op_valid_q;
    assign core.op_a      = op_a_q;
    assign core.op_b      = op_b_q;

    assign rf_rd   = rf_rd_q;
    assign rf_wr   = rf_wr_q;
    assign rf_addr = rf_addr_q;
    assign rf_bus  = rf_wr_q ? wb_data_q : {XLEN{1'bz}};
endmodule

// File: tb/tb_regfile_port_sequencer.sv
// tb/tb_regfile_port_sequencer.sv - directed bench for regfile_port_sequencer with both writeback priorities
module tb_regfile_port_sequencer;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam logic [XLEN-1:0] PROBE = 32'h0F0F_1234;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    regfile_port_sequencer_if #(.XLEN(XLEN), .AW(AW)) ia ();
    regfile_port_sequencer_if #(.XLEN(XLEN), .AW(AW)) ib ();

    logic            ra_rd, ra_wr, rb_rd, rb_wr;
    logic [AW-1:0]   ra_addr, rb_addr;
    wire  [XLEN-1:0] ra_bus, rb_bus;
    logic            probe_en = 1'b0;
    logic [XLEN-1:0] mem_a [32] = '{default: '0};
    logic [XLEN-1:0] mem_b [32] = '{default: '0};
    int              rd_cnt_a = 0;
    int              wr_cnt_a = 0;
    int              checks = 0;
    int              failures = 0;
    int              snap;

    regfile_port_sequencer #(.XLEN(XLEN), .AW(AW), .WB_FIRST(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .core(ia),
        .rf_rd(ra_rd), .rf_wr(ra_wr), .rf_addr(ra_addr), .rf_bus(ra_bus)
    );

    regfile_port_sequencer #(.XLEN(XLEN), .AW(AW), .WB_FIRST(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .core(ib),
        .rf_rd(rb_rd), .rf_wr(rb_wr), .rf_addr(rb_addr), .rf_bus(rb_bus)
    );

    // Register file models: drive on read, capture on write; the probe shows whether the bus is free.
    assign ra_bus = ra_rd ? mem_a[ra_addr] : (probe_en ? PROBE : {XLEN{1'bz}});
    assign rb_bus = rb_rd ? mem_b[rb_addr] : {XLEN{1'bz}};

    always @(posedge clk) begin
        if (ra_wr) mem_a[ra_addr] <= ra_bus;
        if (rb_wr) mem_b[rb_addr] <= rb_bus;
    end

    always @(negedge clk) begin
        if (ra_rd) rd_cnt_a++;
        if (ra_wr) wr_cnt_a++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_a(input logic [AW-1:0] a, input logic [XLEN-1:0] d, input string tag);
        int n = 0;
        ia.wb_valid = 1'b1;
        ia.wb_addr  = a;
        ia.wb_data  = d;
        #1;
        while (!ia.wb_ready && n < 16) begin
            tick();
            n++;
        end
        check(tag, n, 0);
        tick();
        ia.wb_valid = 1'b0;
    endtask

    task automatic fetch_a(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic use2,
                           input string tag);
        int n = 0;
        ia.req_valid   = 1'b1;
        ia.req_rs1     = r1;
        ia.req_rs2     = r2;
        ia.req_use_rs2 = use2;
        #1;
        while (!ia.req_ready && n < 16) begin
            tick();
            n++;
        end
        check(tag, n, 0);
        tick();
        ia.req_valid = 1'b0;
    endtask

    task automatic accept_a(input string tag);
        ia.op_ready = 1'b1;
        tick();
        ia.op_ready = 1'b0;
        check(tag, ia.op_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        {ia.req_valid, ia.req_rs1, ia.req_rs2, ia.req_use_rs2, ia.op_ready} = '0;
        {ia.wb_valid, ia.wb_addr, ia.wb_data} = '0;
        {ib.req_valid, ib.req_rs1, ib.req_rs2, ib.req_use_rs2, ib.op_ready} = '0;
        {ib.wb_valid, ib.wb_addr, ib.wb_data} = '0;

        #1 rst_n = 1'b0;
        ia.wb_valid  = 1'b1;
        ia.req_valid = 1'b1;
        #1;
        check("rst_req_ready", ia.req_ready, 0);
        check("rst_wb_ready", ia.wb_ready, 0);
        check("rst_op_valid", ia.op_valid, 0);
        check("rst_op_a", ia.op_a, 0);
        check("rst_rf_rd", ra_rd, 0);
        check("rst_rf_wr", ra_wr, 0);
        check("rst_rf_addr", ra_addr, 0);
        ia.wb_valid  = 1'b0;
        ia.req_valid = 1'b0;
        #20;
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Writeback r3, then the bus must be released
        wb_a(5'd3, 32'hDEADBEEF, "wb3_wait");
        check("wb3_rf_wr", ra_wr, 1);
        check("wb3_rf_rd", ra_rd, 0);
        check("wb3_addr", ra_addr, 3);
        check("wb3_bus", ra_bus, 32'hDEADBEEF);
        tick();
        check("wb3_wr_drop", ra_wr, 0);
        probe_en = 1'b1;
        #1;
        check("wb3_release", ra_bus, PROBE);
        probe_en = 1'b0;
        check("wb3_mem", mem_a[3], 32'hDEADBEEF);

        // Two-register fetch: RD1, RD2, OUT
        wb_a(5'd5, 32'h12345678, "wb5_wait");
        tick();
        fetch_a(5'd3, 5'd5, 1'b1, "f35_wait");
        check("f35_rd1", ra_rd, 1);
        check("f35_rd1_addr", ra_addr, 3);
        check("f35_rd1_ov", ia.op_valid, 0);
        tick();
        check("f35_rd2", ra_rd, 1);
        check("f35_rd2_addr", ra_addr, 5);
        tick();
        check("f35_ov", ia.op_valid, 1);
        check("f35_op_a", ia.op_a, 32'hDEADBEEF);
        check("f35_op_b", ia.op_b, 32'h12345678);
        check("f35_out_rd", ra_rd, 0);
        check("f35_out_addr", ra_addr, 0);
        accept_a("f35_done");

        // x0 fetch: no bus reads, operands cleared
        snap = rd_cnt_a;
        fetch_a(5'd0, 5'd0, 1'b1, "f00_wait");
        check("f00_ov", ia.op_valid, 1);
        check("f00_op_a", ia.op_a, 0);
        check("f00_op_b", ia.op_b, 0);
        accept_a("f00_done");
        check("f00_no_rd", rd_cnt_a, snap);

        // One register, rs2 not requested
        fetch_a(5'd5, 5'd3, 1'b0, "f5_wait");
        check("f5_addr", ra_addr, 5);
        tick();
        check("f5_ov", ia.op_valid, 1);
        check("f5_op_a", ia.op_a, 32'h12345678);
        check("f5_op_b", ia.op_b, 0);
        accept_a("f5_done");

        // rs1 = x0, rs2 real: straight to RD2
        fetch_a(5'd0, 5'd5, 1'b1, "f05_wait");
        check("f05_rd", ra_rd, 1);
        check("f05_addr", ra_addr, 5);
        tick();
        check("f05_ov", ia.op_valid, 1);
        check("f05_op_a", ia.op_a, 0);
        check("f05_op_b", ia.op_b, 32'h12345678);
        accept_a("f05_done");

        // Writeback to x0: handshake only
        snap = wr_cnt_a;
        wb_a(5'd0, 32'hFFFFFFFF, "wb0_wait");
        check("wb0_no_wr", ra_wr, 0);
        tick();
        tick();
        check("wb0_wr_cnt", wr_cnt_a, snap);
        check("wb0_mem", mem_a[0], 0);

        // Same-cycle wb and fetch, writeback first
        wb_a(5'd7, 32'h11, "wb7a_wait");
        tick();
        ia.wb_valid = 1'b1; ia.wb_addr = 5'd7; ia.wb_data = 32'h55;
        ia.req_valid = 1'b1; ia.req_rs1 = 5'd7; ia.req_rs2 = 5'd0; ia.req_use_rs2 = 1'b0;
        #1;
        check("arbA_wb_ready", ia.wb_ready, 1);
        check("arbA_req_ready", ia.req_ready, 0);
        tick();
        ia.wb_valid = 1'b0;
        check("arbA_wr", ra_wr, 1);
        tick();
        check("arbA_req_ready2", ia.req_ready, 1);
        tick();
        ia.req_valid = 1'b0;
        check("arbA_rd_addr", ra_addr, 7);
        tick();
        check("arbA_ov", ia.op_valid, 1);
        check("arbA_op_a", ia.op_a, 32'h55);
        accept_a("arbA_done");

        // Same-cycle wb and fetch, fetch first
        ib.wb_valid = 1'b1; ib.wb_addr = 5'd7; ib.wb_data = 32'h11;
        #1;
        check("arbB_pre_ready", ib.wb_ready, 1);
        tick();
        ib.wb_valid = 1'b0;
        tick();
        check("arbB_pre_mem", mem_b[7], 32'h11);
        ib.wb_valid = 1'b1; ib.wb_data = 32'h55;
        ib.req_valid = 1'b1; ib.req_rs1 = 5'd7; ib.req_rs2 = 5'd0; ib.req_use_rs2 = 1'b0;
        #1;
        check("arbB_req_ready", ib.req_ready, 1);
        check("arbB_wb_ready", ib.wb_ready, 0);
        tick();
        ib.req_valid = 1'b0;
        check("arbB_rd", rb_rd, 1);
        check("arbB_wb_ready_rd1", ib.wb_ready, 0);
        tick();
        check("arbB_ov", ib.op_valid, 1);
        check("arbB_op_a", ib.op_a, 32'h11);
        ib.op_ready = 1'b1;
        tick();
        ib.op_ready = 1'b0;
        check("arbB_ov_drop", ib.op_valid, 0);
        check("arbB_wb_ready2", ib.wb_ready, 1);
        tick();
        ib.wb_valid = 1'b0;
        check("arbB_wr", rb_wr, 1);
        check("arbB_bus", rb_bus, 32'h55);
        tick();
        check("arbB_mem", mem_b[7], 32'h55);

        // Consumer stall in OUT
        fetch_a(5'd3, 5'd5, 1'b1, "stall_wait");
        tick();
        tick();
        ia.req_valid = 1'b1; ia.req_rs1 = 5'd5; ia.req_use_rs2 = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("stall_ov", ia.op_valid, 1);
            check("stall_op_a", ia.op_a, 32'hDEADBEEF);
            check("stall_op_b", ia.op_b, 32'h12345678);
            check("stall_req_ready", ia.req_ready, 0);
            tick();
        end
        ia.req_valid = 1'b0;
        accept_a("stall_done");
        check("stall_idle_ready", ia.req_ready, 1);

        // Reset in the middle of a write cycle
        wb_a(5'd3, 32'hCAFEF00D, "rstwb_wait");
        check("rstwb_wr_pre", ra_wr, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstwb_wr", ra_wr, 0);
        check("rstwb_addr", ra_addr, 0);
        probe_en = 1'b1;
        #1;
        check("rstwb_release", ra_bus, PROBE);
        probe_en = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("rstwb_idle_ready", ia.req_ready, 1);
        check("rstwb_mem", mem_a[3], 32'hDEADBEEF);
        fetch_a(5'd3, 5'd0, 1'b0, "rstf_wait");
        tick();
        check("rstf_ov", ia.op_valid, 1);
        check("rstf_op_a", ia.op_a, 32'hDEADBEEF);
        accept_a("rstf_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
